// File: rtl/cpu_ctrl_pkg.sv
// Shared definitions for the hardwired control unit: opcodes, control-word bit positions and sequencer states.
// The datapath and the sequencer both import this package so that strobe positions stay in one place.
package cpu_ctrl_pkg;

   localparam int CTRL_W = 24;
   localparam int OP_W   = 5;

   localparam logic [OP_W-1:0] OP_LD   = 5'b00000;
   localparam logic [OP_W-1:0] OP_LDI  = 5'b00001;
   localparam logic [OP_W-1:0] OP_ST   = 5'b00010;
   localparam logic [OP_W-1:0] OP_ADD  = 5'b00011;
   localparam logic [OP_W-1:0] OP_SUB  = 5'b00100;
   localparam logic [OP_W-1:0] OP_AND  = 5'b00101;
   localparam logic [OP_W-1:0] OP_OR   = 5'b00110;
   localparam logic [OP_W-1:0] OP_ADDI = 5'b01011;
   localparam logic [OP_W-1:0] OP_BR   = 5'b10010;
   localparam logic [OP_W-1:0] OP_NOP  = 5'b11001;
   localparam logic [OP_W-1:0] OP_HALT = 5'b11010;

   localparam int CTL_PCOUT     = 0;
   localparam int CTL_ZLOWOUT   = 1;
   localparam int CTL_MDROUT    = 2;
   localparam int CTL_COUT      = 3;
   localparam int CTL_BAOUT     = 4;
   localparam int CTL_ROUT      = 5;
   localparam int CTL_MARIN     = 6;
   localparam int CTL_PCIN      = 7;
   localparam int CTL_MDRIN     = 8;
   localparam int CTL_IRIN      = 9;
   localparam int CTL_YIN       = 10;
   localparam int CTL_INCPC     = 11;
   localparam int CTL_ZIN       = 12;
   localparam int CTL_CONIN     = 13;
   localparam int CTL_RIN       = 14;
   localparam int CTL_GRA       = 15;
   localparam int CTL_GRB       = 16;
   localparam int CTL_GRC       = 17;
   localparam int CTL_READ      = 18;
   localparam int CTL_WRITE     = 19;
   localparam int CTL_ADD       = 20;
   localparam int CTL_SUBTRACT  = 21;
   localparam int CTL_ANDSIGNAL = 22;
   localparam int CTL_ORSIGNAL  = 23;

   // T0..T7 are contiguous so the debug step is simply state - S_T0.
   typedef enum logic [3:0] {
      S_RESET, S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_T6, S_T7, S_PAUSE, S_HALT
   } state_t;

   function automatic logic [4:0] alu_idx(input logic [OP_W-1:0] op);
      case (op)
         OP_SUB:  return 5'(CTL_SUBTRACT);
         OP_AND:  return 5'(CTL_ANDSIGNAL);
         OP_OR:   return 5'(CTL_ORSIGNAL);
         default: return 5'(CTL_ADD);
      endcase
   endfunction

endpackage

// File: rtl/ctrl_decode.sv
// Combinational strobe decoder: (state, opcode, branch flag) -> control word and last-step flag.
// Zero latency; unrecognised opcode/step pairs produce an all-zero word and end the instruction.
module ctrl_decode
   import cpu_ctrl_pkg::*;
(
   input  state_t            state,
   input  logic [OP_W-1:0]   ir_op,
   input  logic              con_ff,
   output logic [CTRL_W-1:0] ctrl,
   output logic              instr_done
);

   always_comb begin
      ctrl       = '0;
      instr_done = 1'b0;
      case (state)
         S_T0: begin
            ctrl[CTL_PCOUT] = 1'b1; ctrl[CTL_MARIN] = 1'b1;
            ctrl[CTL_INCPC] = 1'b1; ctrl[CTL_ZIN]   = 1'b1;
         end
         S_T1: begin
            ctrl[CTL_ZLOWOUT] = 1'b1; ctrl[CTL_PCIN]  = 1'b1;
            ctrl[CTL_READ]    = 1'b1; ctrl[CTL_MDRIN] = 1'b1;
         end
         S_T2: begin
            ctrl[CTL_MDROUT] = 1'b1; ctrl[CTL_IRIN] = 1'b1;
         end
         S_T3: begin
            case (ir_op)
               OP_LD, OP_LDI, OP_ST: begin
                  ctrl[CTL_GRB] = 1'b1; ctrl[CTL_BAOUT] = 1'b1; ctrl[CTL_YIN] = 1'b1;
               end
               OP_ADD, OP_SUB, OP_AND, OP_OR, OP_ADDI: begin
                  ctrl[CTL_GRB] = 1'b1; ctrl[CTL_ROUT] = 1'b1; ctrl[CTL_YIN] = 1'b1;
               end
               OP_BR: begin
                  ctrl[CTL_GRA] = 1'b1; ctrl[CTL_ROUT] = 1'b1; ctrl[CTL_CONIN] = 1'b1;
               end
               default: instr_done = 1'b1;
            endcase
         end
         S_T4: begin
            case (ir_op)
               OP_LD, OP_LDI, OP_ST, OP_ADDI: begin
                  ctrl[CTL_COUT] = 1'b1; ctrl[CTL_ADD] = 1'b1; ctrl[CTL_ZIN] = 1'b1;
               end
               OP_ADD, OP_SUB, OP_AND, OP_OR: begin
                  ctrl[CTL_GRC] = 1'b1; ctrl[CTL_ROUT] = 1'b1; ctrl[CTL_ZIN] = 1'b1;
                  ctrl[alu_idx(ir_op)] = 1'b1;
               end
               OP_BR: begin
                  ctrl[CTL_PCOUT] = 1'b1; ctrl[CTL_YIN] = 1'b1;
               end
               default: instr_done = 1'b1;
            endcase
         end
         S_T5: begin
            case (ir_op)
               OP_LD, OP_ST: begin
                  ctrl[CTL_ZLOWOUT] = 1'b1; ctrl[CTL_MARIN] = 1'b1;
               end
               OP_BR: begin
                  ctrl[CTL_COUT] = 1'b1; ctrl[CTL_ADD] = 1'b1; ctrl[CTL_ZIN] = 1'b1;
               end
               OP_LDI, OP_ADD, OP_SUB, OP_AND, OP_OR, OP_ADDI: begin
                  ctrl[CTL_ZLOWOUT] = 1'b1; ctrl[CTL_GRA] = 1'b1; ctrl[CTL_RIN] = 1'b1;
                  instr_done = 1'b1;
               end
               default: instr_done = 1'b1;
            endcase
         end
         S_T6: begin
            case (ir_op)
               OP_LD: begin
                  ctrl[CTL_READ] = 1'b1; ctrl[CTL_MDRIN] = 1'b1;
               end
               OP_ST: begin
                  ctrl[CTL_GRA] = 1'b1; ctrl[CTL_ROUT] = 1'b1; ctrl[CTL_MDRIN] = 1'b1;
               end
               OP_BR: begin
                  ctrl[CTL_ZLOWOUT] = 1'b1; ctrl[CTL_PCIN] = con_ff;
                  instr_done = 1'b1;
               end
               default: instr_done = 1'b1;
            endcase
         end
         S_T7: begin
            instr_done = 1'b1;
            case (ir_op)
               OP_LD: begin
                  ctrl[CTL_MDROUT] = 1'b1; ctrl[CTL_GRA] = 1'b1; ctrl[CTL_RIN] = 1'b1;
               end
               OP_ST:   ctrl[CTL_WRITE] = 1'b1;
               default: ctrl = '0;
            endcase
         end
         default: ctrl = '0;
      endcase
   end

endmodule

// File: rtl/control_sequencer.sv
// Hardwired control sequencer: fetch T0-T2, per-opcode execute T3-T7, one step per clock.
// stop pauses only at an instruction boundary; clr aborts at once; HALT is left only through clr.
module control_sequencer
   import cpu_ctrl_pkg::*;
(
   input  logic              clk,
   input  logic              clr,
   input  logic [OP_W-1:0]   ir_op,
   input  logic              con_ff,
   input  logic              stop,
   output logic [CTRL_W-1:0] ctrl,
   output logic              run,
   output logic              instr_done,
   output logic [2:0]        step
);

   state_t state;
   state_t state_nxt;

   ctrl_decode u_decode (
      .state      (state),
      .ir_op      (ir_op),
      .con_ff     (con_ff),
      .ctrl       (ctrl),
      .instr_done (instr_done)
   );

   always_ff @(posedge clk) begin
      if (clr) state <= S_RESET;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         S_RESET: state_nxt = S_T0;
         S_PAUSE: state_nxt = stop ? S_PAUSE : S_T0;
         S_HALT:  state_nxt = S_HALT;
         default: begin
            // halt wins over a pending stop request
            if (state == S_T3 && ir_op == OP_HALT)
               state_nxt = S_HALT;
            else if (instr_done || state == S_T7)
               state_nxt = stop ? S_PAUSE : S_T0;
            else
               state_nxt = state_t'(state + 4'd1);
         end
      endcase
   end

   always_comb begin
      run  = (state >= S_T0) && (state <= S_T7);
      step = run ? 3'(state - S_T0) : 3'd0;
   end

endmodule

// File: tb/tb_control_sequencer.sv
// Self-checking bench for control_sequencer: directed opcode table, multi-cycle corner sequences
// and a randomised run against an instruction-level reference model.
module tb_control_sequencer;

   logic        clk = 1'b0;
   logic        clr = 1'b1;
   logic [4:0]  ir_op = 5'd0;
   logic        con_ff = 1'b0;
   logic        stop = 1'b0;
   logic [23:0] ctrl;
   logic        run;
   logic        instr_done;
   logic [2:0]  step;

   control_sequencer dut (
      .clk(clk), .clr(clr), .ir_op(ir_op), .con_ff(con_ff), .stop(stop),
      .ctrl(ctrl), .run(run), .instr_done(instr_done), .step(step)
   );

   always #5 clk = ~clk;

   localparam int PCO = 0, ZLO = 1, MDRO = 2, CO = 3, BAO = 4, RO = 5, MARI = 6, PCI = 7;
   localparam int MDRI = 8, IRI = 9, YI = 10, INCPC = 11, ZI = 12, CONI = 13, RI = 14, GRA = 15;
   localparam int GRB = 16, GRC = 17, RD = 18, WR = 19, ADD = 20, SUB = 21, ANDS = 22, ORS = 23;

   localparam logic [4:0] LD = 5'b00000, LDI = 5'b00001, ST = 5'b00010, ADDO = 5'b00011;
   localparam logic [4:0] SUBO = 5'b00100, ANDO = 5'b00101, ORO = 5'b00110, ADDI = 5'b01011;
   localparam logic [4:0] BR = 5'b10010, NOP = 5'b11001, HALT = 5'b11010;

   localparam logic [23:0] FETCH0 = 24'h001841;

   int total = 0;
   int bad   = 0;

   typedef struct {
      logic [4:0]  op;
      logic        con;
      int          n;
      logic [23:0] t3;
      logic [23:0] t4;
      logic [23:0] last;
   } vec_t;

   vec_t vt[13];

   logic [23:0] w[8];
   int          n_steps;

   function automatic logic [23:0] b(input int i);
      return 24'd1 << i;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic step_clk();
      @(posedge clk);
      #1;
   endtask

   // Instruction-level reference: the step list each opcode walks through.
   task automatic build(input logic [4:0] op, input logic c);
      w[0] = b(PCO) | b(MARI) | b(INCPC) | b(ZI);
      w[1] = b(ZLO) | b(PCI) | b(RD) | b(MDRI);
      w[2] = b(MDRO) | b(IRI);
      for (int i = 3; i < 8; i++) w[i] = '0;
      case (op)
         LD, ST, LDI: begin
            w[3] = b(GRB) | b(BAO) | b(YI);
            w[4] = b(CO) | b(ADD) | b(ZI);
            if (op == LDI) begin
               w[5] = b(ZLO) | b(GRA) | b(RI); n_steps = 6;
            end else begin
               w[5] = b(ZLO) | b(MARI); n_steps = 8;
               w[6] = (op == LD) ? (b(RD) | b(MDRI)) : (b(GRA) | b(RO) | b(MDRI));
               w[7] = (op == LD) ? (b(MDRO) | b(GRA) | b(RI)) : b(WR);
            end
         end
         ADDO, SUBO, ANDO, ORO, ADDI: begin
            w[3] = b(GRB) | b(RO) | b(YI);
            case (op)
               ADDO:    w[4] = b(GRC) | b(RO) | b(ADD) | b(ZI);
               SUBO:    w[4] = b(GRC) | b(RO) | b(SUB) | b(ZI);
               ANDO:    w[4] = b(GRC) | b(RO) | b(ANDS) | b(ZI);
               ORO:     w[4] = b(GRC) | b(RO) | b(ORS) | b(ZI);
               default: w[4] = b(CO) | b(ADD) | b(ZI);
            endcase
            w[5] = b(ZLO) | b(GRA) | b(RI);
            n_steps = 6;
         end
         BR: begin
            w[3] = b(GRA) | b(RO) | b(CONI);
            w[4] = b(PCO) | b(YI);
            w[5] = b(CO) | b(ADD) | b(ZI);
            w[6] = b(ZLO) | (c ? b(PCI) : 24'd0);
            n_steps = 7;
         end
         default: n_steps = 4;
      endcase
   endtask

   // Entered while the DUT sits in T0; leaves it in the following T0.
   task automatic run_vec(input vec_t v, input int id);
      ir_op = v.op; con_ff = v.con; stop = 1'b0;
      #1;
      for (int k = 0; k < v.n; k++) begin
         chk($sformatf("v%0d_step%0d", id, k), 32'(step), 32'(k));
         chk($sformatf("v%0d_run%0d", id, k), 32'(run), 32'd1);
         chk($sformatf("v%0d_done%0d", id, k), 32'(instr_done), 32'(k == v.n - 1));
         chk($sformatf("v%0d_rdwr%0d", id, k), 32'(ctrl[RD] & ctrl[WR]), 32'd0);
         if (k == 0) chk($sformatf("v%0d_t0", id), 32'(ctrl), 32'(FETCH0));
         if (k == 3) chk($sformatf("v%0d_t3", id), 32'(ctrl), 32'(v.t3));
         if (k == 4 && v.n > 5) chk($sformatf("v%0d_t4", id), 32'(ctrl), 32'(v.t4));
         if (k == v.n - 1) chk($sformatf("v%0d_last", id), 32'(ctrl), 32'(v.last));
         step_clk();
      end
      chk($sformatf("v%0d_next_t0", id), {28'd0, run, step}, 32'h8);
   endtask

   initial begin
      logic [4:0]  ops[11];
      int          mode;
      int          idx;
      logic [4:0]  cur_op;
      logic [23:0] e_ctrl;

      vt[0]  = '{LD,   1'b0, 8, 24'h010410, 24'h101008, 24'h00C004};
      vt[1]  = '{LDI,  1'b0, 6, 24'h010410, 24'h101008, 24'h00C002};
      vt[2]  = '{ST,   1'b0, 8, 24'h010410, 24'h101008, 24'h080000};
      vt[3]  = '{ADDO, 1'b0, 6, 24'h010420, 24'h121020, 24'h00C002};
      vt[4]  = '{SUBO, 1'b0, 6, 24'h010420, 24'h221020, 24'h00C002};
      vt[5]  = '{ANDO, 1'b0, 6, 24'h010420, 24'h421020, 24'h00C002};
      vt[6]  = '{ORO,  1'b0, 6, 24'h010420, 24'h821020, 24'h00C002};
      vt[7]  = '{ADDI, 1'b0, 6, 24'h010420, 24'h101008, 24'h00C002};
      vt[8]  = '{BR,   1'b0, 7, 24'h00A020, 24'h000401, 24'h000002};
      vt[9]  = '{BR,   1'b1, 7, 24'h00A020, 24'h000401, 24'h000082};
      vt[10] = '{NOP,  1'b0, 4, 24'h000000, 24'h000000, 24'h000000};
      vt[11] = '{5'b00111, 1'b1, 4, 24'h000000, 24'h000000, 24'h000000};
      vt[12] = '{5'b11111, 1'b0, 4, 24'h000000, 24'h000000, 24'h000000};

      // Reset entry and first fetch step
      clr = 1'b1;
      step_clk(); step_clk();
      chk("rst_ctrl", 32'(ctrl), 32'd0);
      chk("rst_flags", {29'd0, run, instr_done, 1'b0}, 32'd0);
      chk("rst_step", 32'(step), 32'd0);
      clr = 1'b0;
      #1;
      chk("rst_hold_ctrl", 32'(ctrl), 32'd0);
      chk("rst_hold_run", 32'(run), 32'd0);
      step_clk();
      chk("first_t0_run", 32'(run), 32'd1);
      chk("first_t0_ctrl", 32'(ctrl), 32'(FETCH0));

      for (int i = 0; i < 13; i++) run_vec(vt[i], i);

      // stop raised mid-instruction: add completes, then pauses
      ir_op = ADDO; con_ff = 1'b0;
      repeat (4) step_clk();
      stop = 1'b1;
      #1;
      chk("stop_at_t4", 32'(step), 32'd4);
      step_clk();
      chk("stop_t5_done", 32'(instr_done), 32'd1);
      chk("stop_t5_ctrl", 32'(ctrl), 32'h00C002);
      step_clk();
      chk("pause_run", 32'(run), 32'd0);
      chk("pause_ctrl", 32'(ctrl), 32'd0);
      step_clk();
      chk("pause_held", 32'(run), 32'd0);
      stop = 1'b0;
      step_clk();
      chk("unpause_t0", {28'd0, run, step}, 32'h8);
      chk("unpause_ctrl", 32'(ctrl), 32'(FETCH0));

      // clr during T6 of st: the write step must never appear
      ir_op = ST;
      repeat (6) step_clk();
      chk("st_at_t6", 32'(step), 32'd6);
      clr = 1'b1;
      step_clk();
      chk("abort_run", 32'(run), 32'd0);
      chk("abort_ctrl", 32'(ctrl), 32'd0);
      clr = 1'b0;
      #1;
      chk("abort_no_write", 32'(ctrl[WR]), 32'd0);
      step_clk();
      chk("abort_t0", {28'd0, run, step}, 32'h8);

      // halt with stop pending: HALT wins and holds
      ir_op = HALT; stop = 1'b1;
      repeat (3) step_clk();
      chk("halt_t3_step", 32'(step), 32'd3);
      chk("halt_t3_ctrl", 32'(ctrl), 32'd0);
      step_clk();
      chk("halt_run", 32'(run), 32'd0);
      stop = 1'b0;
      repeat (4) step_clk();
      chk("halt_held", {8'd0, ctrl, 4'd0, run, step}, 32'd0);
      clr = 1'b1;
      step_clk();
      clr = 1'b0;
      step_clk();
      chk("halt_exit_t0", {28'd0, run, step}, 32'h8);

      // Randomised run against the instruction-level model
      ops = '{LD, LDI, ST, ADDO, SUBO, ANDO, ORO, ADDI, BR, NOP, HALT};
      clr = 1'b1;
      step_clk();
      mode = 0; idx = 0; cur_op = NOP; n_steps = 4;
      for (int c = 0; c < 3000; c++) begin
         if (mode == 1 && idx == 0) begin
            int r;
            r = $urandom_range(0, 19);
            if (r < 10)       cur_op = ops[r];
            else if (r < 18)  cur_op = ops[$urandom_range(0, 8)];
            else if (r == 18) cur_op = HALT;
            else              cur_op = 5'($urandom_range(0, 31));
            con_ff = 1'($urandom_range(0, 1));
            build(cur_op, con_ff);
            ir_op = cur_op;
         end
         stop = ($urandom_range(0, 3) == 0);
         clr  = (mode == 3) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 99) == 0);
         #1;
         e_ctrl = (mode == 1) ? w[idx] : 24'd0;
         chk("rnd_ctrl", 32'(ctrl), 32'(e_ctrl));
         chk("rnd_step", 32'(step), (mode == 1) ? 32'(idx) : 32'd0);
         chk("rnd_run", 32'(run), 32'(mode == 1));
         chk("rnd_done", 32'(instr_done), 32'(mode == 1 && idx == n_steps - 1));
         chk("rnd_one_driver", 32'($countones(ctrl[5:0]) <= 1), 32'd1);
         chk("rnd_rdwr", 32'(ctrl[RD] & ctrl[WR]), 32'd0);
         chk("rnd_alu_onehot", 32'($countones(ctrl[23:20]) <= 1), 32'd1);
         step_clk();
         if (clr) mode = 0;
         else case (mode)
            0: begin mode = 1; idx = 0; end
            1: begin
               if (idx == n_steps - 1) begin
                  if (cur_op == HALT) mode = 3;
                  else if (stop)      mode = 2;
                  idx = 0;
               end else idx++;
            end
            2: if (!stop) begin mode = 1; idx = 0; end
            default: mode = 3;
         endcase
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
